// File: rtl/rr_arbiter_10.sv
// Round-robin arbiter: ten requesters share one resource. Grant is registered and one-hot, with a 4-bit index.
// Latency: a request sampled in IDLE is granted after the next edge. Each release is followed by one idle turnaround cycle.
// Backpressure: none. A holder keeps the grant while its request stays high, up to MAX_HOLD cycles when HOLD_EN=1.
module rr_arbiter_10 #(
  parameter int MAX_HOLD = 8,
  parameter bit HOLD_EN  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] req,
  output logic [9:0] grant,
  output logic [3:0] grant_id,
  output logic       grant_valid
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state;
  logic [3:0] ptr;
  logic [3:0] hold_cnt;
  logic       win_found;
  logic [3:0] win_id;
  logic [4:0] idx;
  logic       release_now;

  // First set request at or above ptr, wrapping 9 -> 0.
  always_comb begin
    win_found = 1'b0;
    win_id    = 4'd0;
    idx       = 5'd0;
    for (int i = 0; i < 10; i++) begin
      idx = {1'b0, ptr} + 5'(i);
      if (idx >= 5'd10) idx = idx - 5'd10;
      if (!win_found && req[idx[3:0]]) begin
        win_found = 1'b1;
        win_id    = idx[3:0];
      end
    end
  end

  // The holder's request bit is found by masking req with the one-hot grant.
  assign release_now = ((req & grant) == 10'd0) ||
                       ((HOLD_EN == 1'b1) && (hold_cnt == 4'(MAX_HOLD - 1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= 4'd0;
      hold_cnt    <= 4'd0;
      grant       <= 10'd0;
      grant_id    <= 4'hF;
      grant_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            state       <= GRANT;
            grant       <= 10'd1 << win_id;
            grant_id    <= win_id;
            grant_valid <= 1'b1;
            hold_cnt    <= 4'd0;
            ptr         <= (win_id == 4'd9) ? 4'd0 : win_id + 4'd1;
          end
        end
        GRANT: begin
          if (release_now) begin
            state       <= IDLE;
            grant       <= 10'd0;
            grant_id    <= 4'hF;
            grant_valid <= 1'b0;
          end else if (hold_cnt != 4'hF) begin
            hold_cnt <= hold_cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
